case_1_mul_pipe_hs: RTL and testbench

//   Parametrised, pipelined integer multiplier with valid/ready handshake.

---
 rtl/case_1_mul_pkg.sv | 33 +++
 rtl/case_1_mul_pipe_stage.sv | 47 ++++
 rtl/case_1_mul_pipe_hs.sv | 126 ++++++++++++
 tb/tb_case_1_mul_pipe_hs.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/case_1_mul_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// case_1_mul_pkg : width and clipping helpers for case_1_mul_pipe_hs. Rev 1.0
// ----------------------------------------------------------------------------
package case_1_mul_pkg;

  localparam int SAT_W = 64;

  typedef enum logic {
    RES_UNSIGNED = 1'b0,
    RES_SIGNED   = 1'b1
  } res_mode_e;

  function automatic int prod_width(input int w0, input int w1);
    return w0 + w1;
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_max(input int width, input logic is_signed);
    logic signed [SAT_W-1:0] one;
    one = 1;
    if (is_signed) return (one <<< (width - 1)) - one;
    else           return (one <<< width) - one;
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_min(input int width, input logic is_signed);
    logic signed [SAT_W-1:0] one;
    one = 1;
    if (is_signed) return -(one <<< (width - 1));
    else           return '0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/case_1_mul_pipe_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// case_1_mul_pipe_stage : one valid+data slice, fills whenever empty or draining. Rev 1.0
// ----------------------------------------------------------------------------
module case_1_mul_pipe_stage
  import case_1_mul_pkg::*;
#(
  parameter int WIDTH = 20
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             up_valid_i,
  input  logic [WIDTH-1:0] up_data_i,
  input  logic             dn_ready_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  assign ready_o = !valid_q || dn_ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (ready_o) begin
      valid_d = up_valid_i;
      if (up_valid_i) data_d = up_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/case_1_mul_pipe_hs.sv
`default_nettype none
// ----------------------------------------------------------------------------
// case_1_mul_pipe_hs : pipelined signed/unsigned multiplier, valid/ready handshake.
// Define MUL_PIPE_SAT_EN to clip narrow results instead of wrapping. Rev 1.0
// ----------------------------------------------------------------------------
module case_1_mul_pipe_hs
  import case_1_mul_pkg::*;
#(
  parameter int ID          = 1,
  parameter int NUM_STAGE   = 3,
  parameter int DIN0_WIDTH  = 10,
  parameter int DIN1_WIDTH  = 9,
  parameter int DOUT_WIDTH  = 19,
  parameter int DIN0_SIGNED = 1,
  parameter int DIN1_SIGNED = 1
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  busy,
  output logic                  sat_flag
);

  localparam int P  = prod_width(DIN0_WIDTH, DIN1_WIDTH);
  // Two guard bits cover the 1-bit zero-extension of unsigned operands.
  localparam int PX = P + 2;
  localparam int MW = (DOUT_WIDTH > PX) ? DOUT_WIDTH : PX;
  localparam int SW = DOUT_WIDTH + 1;

  if (NUM_STAGE < 1 || ID < 0) begin : g_param_chk
    $error("case_1_mul_pipe_hs: NUM_STAGE must be >= 1 and ID non-negative");
  end

  logic signed [MW-1:0]  a_x, b_x;
  logic [DOUT_WIDTH-1:0] res_w;
  logic                  sat_w;

  if (DIN0_SIGNED != 0) begin : g_a_signed
    assign a_x = MW'($signed(din0));
  end else begin : g_a_unsigned
    assign a_x = MW'(din0);
  end

  if (DIN1_SIGNED != 0) begin : g_b_signed
    assign b_x = MW'($signed(din1));
  end else begin : g_b_unsigned
    assign b_x = MW'(din1);
  end

`ifdef MUL_PIPE_SAT_EN
  if (DOUT_WIDTH < P) begin : g_sat
    localparam res_mode_e RES_MODE = (DIN0_SIGNED != 0 || DIN1_SIGNED != 0) ? RES_SIGNED : RES_UNSIGNED;
    localparam logic signed [MW-1:0] HI = MW'(sat_max(DOUT_WIDTH, RES_MODE == RES_SIGNED));
    localparam logic signed [MW-1:0] LO = MW'(sat_min(DOUT_WIDTH, RES_MODE == RES_SIGNED));
    logic signed [MW-1:0] prod;
    assign prod = a_x * b_x;
    always_comb begin
      res_w = DOUT_WIDTH'(prod);
      sat_w = 1'b0;
      if (prod > HI) begin
        res_w = DOUT_WIDTH'(HI);
        sat_w = 1'b1;
      end else if (prod < LO) begin
        res_w = DOUT_WIDTH'(LO);
        sat_w = 1'b1;
      end
    end
  end else begin : g_nosat
    assign res_w = DOUT_WIDTH'(a_x * b_x);
    assign sat_w = 1'b0;
  end
`else
  assign res_w = DOUT_WIDTH'(a_x * b_x);
  assign sat_w = 1'b0;
`endif

  logic [NUM_STAGE-1:0] vld_vec;

  for (genvar k = 0; k < NUM_STAGE; k++) begin : g_stage
    logic          up_valid, dn_ready, rdy, vld;
    logic [SW-1:0] up_data, dat;

    if (k == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_data  = {sat_w, res_w};
    end else begin : g_body
      assign up_valid = g_stage[k-1].vld;
      assign up_data  = g_stage[k-1].dat;
    end

    if (k == NUM_STAGE - 1) begin : g_tail
      assign dn_ready = out_ready;
    end else begin : g_link
      assign dn_ready = g_stage[k+1].rdy;
    end

    case_1_mul_pipe_stage #(
      .WIDTH(SW)
    ) u_stage (
      .clk_i      (ap_clk),
      .rst_ni     (ap_rst_n),
      .up_valid_i (up_valid),
      .up_data_i  (up_data),
      .dn_ready_i (dn_ready),
      .ready_o    (rdy),
      .valid_o    (vld),
      .data_o     (dat)
    );

    assign vld_vec[k] = vld;
  end

  assign in_ready  = g_stage[0].rdy;
  assign out_valid = g_stage[NUM_STAGE-1].vld;
  assign dout      = g_stage[NUM_STAGE-1].dat[DOUT_WIDTH-1:0];
  assign sat_flag  = out_valid && g_stage[NUM_STAGE-1].dat[DOUT_WIDTH];
  assign busy      = |vld_vec;

endmodule
`default_nettype wire

// File: tb/tb_case_1_mul_pipe_hs.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_case_1_mul_pipe_hs : randomized + directed bench with arithmetic reference. Rev 1.0
// ----------------------------------------------------------------------------
module tb_case_1_mul_pipe_hs;

`ifdef MUL_PIPE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [9:0]  din0;
  logic [8:0]  din1;
  logic        out_ready;

  logic        m_in_ready, m_out_valid, m_busy, m_sat;
  logic [18:0] m_dout;
  logic        w_in_ready, w_out_valid, w_busy, w_sat;
  logic [15:0] w_dout;
  logic        a_in_ready, a_out_valid, a_busy, a_sat;
  logic [18:0] a_dout;
  logic        b_in_ready, b_out_valid, b_busy, b_sat;
  logic [18:0] b_dout;

  always #5 clk = ~clk;

  case_1_mul_pipe_hs u_dut (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(m_in_ready),
    .din0(din0), .din1(din1), .out_valid(m_out_valid), .out_ready(out_ready),
    .dout(m_dout), .busy(m_busy), .sat_flag(m_sat));

  case_1_mul_pipe_hs #(.DOUT_WIDTH(16)) u_w16 (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
    .din0(din0), .din1(din1), .out_valid(w_out_valid), .out_ready(1'b1),
    .dout(w_dout), .busy(w_busy), .sat_flag(w_sat));

  case_1_mul_pipe_hs #(.DIN0_SIGNED(0)) u_u0 (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .din0(din0), .din1(din1), .out_valid(a_out_valid), .out_ready(1'b1),
    .dout(a_dout), .busy(a_busy), .sat_flag(a_sat));

  case_1_mul_pipe_hs #(.DIN0_SIGNED(0), .DIN1_SIGNED(0)) u_u01 (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .din0(din0), .din1(din1), .out_valid(b_out_valid), .out_ready(1'b1),
    .dout(b_dout), .busy(b_busy), .sat_flag(b_sat));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [63:0] v;
    logic        f;
  } exp_t;

  // Exact integer product, then clip or wrap to the output width.
  function automatic exp_t model(input logic [9:0] a, input logic [8:0] b,
                                 input bit s0, input bit s1, input int dw);
    exp_t   r;
    longint av, bv, p, hi, lo;
    if (s0) av = longint'($signed(a)); else av = longint'(a);
    if (s1) bv = longint'($signed(b)); else bv = longint'(b);
    p   = av * bv;
    r.f = 1'b0;
    if (SAT && dw < 19) begin
      if (s0 || s1) begin
        hi = (64'sd1 <<< (dw - 1)) - 1;
        lo = -(64'sd1 <<< (dw - 1));
      end else begin
        hi = (64'sd1 <<< dw) - 1;
        lo = 0;
      end
      if (p > hi) begin p = hi; r.f = 1'b1; end
      else if (p < lo) begin p = lo; r.f = 1'b1; end
    end
    r.v = 64'(p & ((64'sd1 <<< dw) - 1));
    return r;
  endfunction

  exp_t        q_m[$], q_w[$], q_a[$], q_b[$];
  logic        prev_stall = 1'b0;
  logic [18:0] prev_dout  = '0;

  always @(negedge clk) begin : sb
    exp_t e;
    if (!rst_n) begin
      q_m.delete(); q_w.delete(); q_a.delete(); q_b.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 64'(m_out_valid), 64'd1);
        check("hold_dout", 64'(m_dout), 64'(prev_dout));
      end
      prev_stall = m_out_valid && !out_ready;
      prev_dout  = m_dout;

      if (m_out_valid && out_ready) begin
        if (q_m.size() == 0) check("m_extra_output", 64'd1, 64'd0);
        else begin
          e = q_m.pop_front();
          check("m_dout", 64'(m_dout), e.v);
          check("m_sat", 64'(m_sat), 64'(e.f));
        end
      end
      if (w_out_valid) begin
        if (q_w.size() == 0) check("w16_extra_output", 64'd1, 64'd0);
        else begin
          e = q_w.pop_front();
          check("w16_dout", 64'(w_dout), e.v);
          check("w16_sat", 64'(w_sat), 64'(e.f));
        end
      end
      if (a_out_valid) begin
        if (q_a.size() == 0) check("u0_extra_output", 64'd1, 64'd0);
        else begin
          e = q_a.pop_front();
          check("u0_dout", 64'(a_dout), e.v);
        end
      end
      if (b_out_valid) begin
        if (q_b.size() == 0) check("u01_extra_output", 64'd1, 64'd0);
        else begin
          e = q_b.pop_front();
          check("u01_dout", 64'(b_dout), e.v);
        end
      end

      if (in_valid && m_in_ready) q_m.push_back(model(din0, din1, 1'b1, 1'b1, 19));
      if (in_valid && w_in_ready) q_w.push_back(model(din0, din1, 1'b1, 1'b1, 16));
      if (in_valid && a_in_ready) q_a.push_back(model(din0, din1, 1'b0, 1'b1, 19));
      if (in_valid && b_in_ready) q_b.push_back(model(din0, din1, 1'b0, 1'b0, 19));
    end
  end

  task automatic one_shot(input logic [9:0] a, input logic [8:0] b, output int lat);
    @(posedge clk); #1;
    in_valid = 1'b1; din0 = a; din1 = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!m_out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int          lat, acc, ones, rises;
    logic [19:0] ov;
    rst_n = 1'b0; in_valid = 1'b0; din0 = '0; din1 = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(m_out_valid), 64'd0);
    check("rst_busy", 64'(m_busy), 64'd0);
    check("rst_dout", 64'(m_dout), 64'd0);
    check("rst_sat", 64'(m_sat), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Latency and value of the corner product, plus the narrow-output variant.
    one_shot(10'h200, 9'h100, lat);
    check("t1_latency", 64'(lat), 64'd3);
    check("t1_dout", 64'(m_dout), 64'd131072);
    check("t4_w16_dout", 64'(w_dout), SAT ? 64'd32767 : 64'd0);
    check("t4_w16_sat", 64'(w_sat), SAT ? 64'd1 : 64'd0);

    // Unsigned operand handling: 1023 * -1 and 1023 * 511.
    one_shot(10'h3FF, 9'h1FF, lat);
    check("t5_latency", 64'(lat), 64'd3);
    check("t5_u0_dout", 64'(a_dout), 64'd523265);
    check("t5_u01_dout", 64'(b_dout), 64'd522753);
    repeat (4) @(posedge clk);

    // Back-to-back stream of 8 operand pairs.
    ov = '0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      in_valid = (i < 8);
      din0 = 10'(i); din1 = 9'(i + 1);
      if (i < 8) check("t2_in_ready", 64'(m_in_ready), 64'd1);
      ov[i] = m_out_valid;
    end
    ones = 0; rises = 0;
    for (int i = 0; i < 20; i++) begin
      if (ov[i]) ones++;
      if (ov[i] && (i == 0 || !ov[i-1])) rises++;
    end
    check("t2_result_count", 64'(ones), 64'd8);
    check("t2_contiguous", 64'(rises), 64'd1);

    // Backpressure: capacity equals the stage count.
    @(posedge clk); #1;
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; din0 = 10'($urandom); din1 = 9'($urandom);
      @(negedge clk);
      if (in_valid && m_in_ready) acc++;
      @(posedge clk); #1;
    end
    check("t3_accepted", 64'(acc), 64'd3);
    check("t3_in_ready_full", 64'(m_in_ready), 64'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (8) @(posedge clk);

    // Reset with two items in flight.
    #1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; din0 = 10'($urandom); din1 = 9'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("t6_out_valid", 64'(m_out_valid), 64'd0);
    check("t6_busy", 64'(m_busy), 64'd0);
    check("t6_dout", 64'(m_dout), 64'd0);
    check("t6_w16_busy", 64'(w_busy), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("t6_no_stale", 64'(m_out_valid || a_out_valid || b_out_valid), 64'd0);
    end

    // Randomized traffic with random backpressure and corner operands.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       din0 = 10'h200;
        1:       din0 = 10'h1FF;
        default: din0 = 10'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0:       din1 = 9'h100;
        1:       din1 = 9'h0FF;
        default: din1 = 9'($urandom);
      endcase
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("drain_main", 64'(q_m.size()), 64'd0);
    check("drain_w16", 64'(q_w.size()), 64'd0);
    check("drain_u0", 64'(q_a.size()), 64'd0);
    check("drain_u01", 64'(q_b.size()), 64'd0);
    check("drain_busy", 64'(m_busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
